tx_edge_pulse: RTL and testbench
================================

TX_EDGE_PULSE -- requirements
Module: tx_edge_pulse

Interface
REQ-001 Parameter NCH, default 4: number of independent channels, range 1..16.
REQ-002 Parameter CNT_W, default 4: width of the delay and pulse-length counters, range 2..8.
REQ-003 clk  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 tx_en  input  NCH  per-channel transmit enable, synchronous to clk.
REQ-006 mode  input  2  edge select: 00 falling, 01 rising, 10 both, 11 disabled; shared by all channels.
REQ-007 delay  input  CNT_W  cycles between the detected edge and the pulse start; shared.
REQ-008 pulse_len  input  CNT_W  pulse width in cycles; 0 is treated as 1; shared.
REQ-009 done_clr  input  NCH  per-channel one-cycle clear of the done flag.
REQ-010 irq_en  input  NCH  per-channel interrupt enable.
REQ-011 tx_cek  output  NCH  registered per-channel check pulse.
REQ-012 done  output  NCH  sticky per-channel completion flag.
REQ-013 ovr  output  NCH  sticky per-channel overrun flag, cleared by done_clr.
REQ-014 irq  output  1  registered OR of (done & irq_en).

Function
REQ-015 Each channel SHALL hold a prev register that samples tx_en[i] every cycle.
REQ-016 Qualifying edge: falling = prev 1, tx_en 0; rising = prev 0, tx_en 1; both = either; disabled = never.
REQ-017 Each channel SHALL run an FSM with states IDLE, WAIT, PULSE and one CNT_W-bit down-counter.
REQ-018 IDLE, qualifying edge, delay = 0 -> PULSE, counter loads max(pulse_len,1).
REQ-019 IDLE, qualifying edge, delay > 0 -> WAIT, counter loads delay.
REQ-020 WAIT: counter decrements; when counter = 1 -> PULSE, counter loads max(pulse_len,1).
REQ-021 PULSE: tx_cek[i] = 1; counter decrements; when counter = 1 -> IDLE and done[i] sets.
REQ-022 Latency: an edge sampled at clock k SHALL give tx_cek[i] high for cycles k+1+delay .. k+delay+max(pulse_len,1).
REQ-023 Abort (falling/rising modes): tx_en[i] back at its pre-edge level during WAIT or PULSE -> IDLE next cycle, tx_cek[i] drops, done[i] not set.
REQ-024 Both mode: no abort; an edge during WAIT or PULSE SHALL set ovr[i] and is otherwise dropped.
REQ-025 mode = 11 SHALL force every channel to IDLE on the next clock with tx_cek = 0; done and ovr hold.
REQ-026 delay and pulse_len SHALL be sampled only when loaded into the counter; later changes do not affect a pulse in flight.
REQ-027 done[i] set and done_clr[i] in the same cycle: set SHALL win; the same rule applies to ovr[i].
REQ-028 irq SHALL update one cycle after done or irq_en changes.
REQ-029 Channels SHALL be fully independent; simultaneous edges on all channels SHALL each be serviced.
REQ-030 Counter arithmetic SHALL be unsigned CNT_W-bit; the counter never wraps below 1 while in WAIT or PULSE.

Reset
REQ-031 While reset is low: all FSMs IDLE; counters 0; tx_cek, done, ovr and irq = 0; prev = all ones.
REQ-032 prev = 1 at reset means tx_en low after reset release counts as a falling edge in falling mode, so a check pulse follows (intentional).
REQ-033 Reset asserted mid-WAIT or mid-PULSE SHALL drop tx_cek immediately (asynchronously) and discard the pending pulse.

Verification
REQ-034 mode=00, delay=0, pulse_len=1, tx_en[0] 1->0 at clock 10 -> tx_cek[0] high in cycle 11 only; done[0]=1 from cycle 12; irq=1 from cycle 13 if irq_en[0]=1.
REQ-035 mode=00, delay=3, pulse_len=4, falling edge at clock 20 -> tx_cek high in cycles 24..27; change pulse_len to 1 at cycle 22 -> width still 4.
REQ-036 mode=00, delay=2, pulse_len=4, tx_en falls, rises 1 cycle later -> no tx_cek, done stays 0.
REQ-037 mode=10, delay=0, pulse_len=5, edges at clocks 0 and 2 -> one pulse in cycles 1..5, ovr=1; done_clr coinciding with done set -> done stays 1.
REQ-038 Reset low while tx_cek[1]=1 -> tx_cek, done, ovr and irq = 0 at once; release with tx_en=0 in mode 00 -> pulse 1+delay cycles later.
REQ-039 NCH=4, all tx_en fall together, mode=00 -> four identical concurrent pulses; mode=11 mid-pulse -> all tx_cek = 0 next cycle.

Source files
------------

// File: rtl/tx_edge_pulse.sv
// Multi-channel edge-triggered pulse generator: a qualifying edge on tx_en starts an optional
// delay followed by a check pulse on tx_cek, with sticky done/overrun flags and an interrupt.
module tx_edge_pulse #(
    parameter int unsigned NCH   = 4,
    parameter int unsigned CNT_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NCH-1:0]   tx_en,
    input  logic [1:0]       mode,
    input  logic [CNT_W-1:0] delay,
    input  logic [CNT_W-1:0] pulse_len,
    input  logic [NCH-1:0]   done_clr,
    input  logic [NCH-1:0]   irq_en,
    output logic [NCH-1:0]   tx_cek,
    output logic [NCH-1:0]   done,
    output logic [NCH-1:0]   ovr,
    output logic             irq
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_PULSE = 2'd2;

    localparam logic [1:0] MODE_FALL = 2'b00;
    localparam logic [1:0] MODE_RISE = 2'b01;
    localparam logic [1:0] MODE_BOTH = 2'b10;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NCH-1:0]   prev_q;
    logic [1:0]       state_q [NCH];
    logic [1:0]       state_d [NCH];
    logic [CNT_W-1:0] cnt_q   [NCH];
    logic [CNT_W-1:0] cnt_d   [NCH];
    logic [NCH-1:0]   tx_cek_q, tx_cek_d;
    logic [NCH-1:0]   done_q, done_d;
    logic [NCH-1:0]   ovr_q, ovr_d;
    logic             irq_q;

    logic [NCH-1:0]   rise, fall, edge_hit, abort;
    logic [CNT_W-1:0] pulse_load;

    assign pulse_load = (pulse_len == '0) ? CNT_ONE : pulse_len;
    assign rise       = ~prev_q & tx_en;
    assign fall       = prev_q & ~tx_en;

    // Abort fires when the line returns to the level it had before the triggering edge.
    always_comb begin
        edge_hit = '0;
        abort    = '0;
        case (mode)
            MODE_FALL: begin
                edge_hit = fall;
                abort    = tx_en;
            end
            MODE_RISE: begin
                edge_hit = rise;
                abort    = ~tx_en;
            end
            MODE_BOTH: edge_hit = rise | fall;
            default: ;
        endcase
    end

    always_comb begin
        for (int i = 0; i < NCH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            done_d[i]  = done_q[i] & ~done_clr[i];
            ovr_d[i]   = ovr_q[i] & ~done_clr[i];
            if (mode == 2'b11) begin
                state_d[i] = ST_IDLE;
                cnt_d[i]   = '0;
            end else begin
                case (state_q[i])
                    ST_IDLE: begin
                        if (edge_hit[i]) begin
                            if (delay == '0) begin
                                state_d[i] = ST_PULSE;
                                cnt_d[i]   = pulse_load;
                            end else begin
                                state_d[i] = ST_WAIT;
                                cnt_d[i]   = delay;
                            end
                        end
                    end
                    ST_WAIT: begin
                        if (abort[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            if (edge_hit[i]) ovr_d[i] = 1'b1;
                            if (cnt_q[i] <= CNT_ONE) begin
                                state_d[i] = ST_PULSE;
                                cnt_d[i]   = pulse_load;
                            end else begin
                                cnt_d[i] = cnt_q[i] - CNT_ONE;
                            end
                        end
                    end
                    ST_PULSE: begin
                        if (abort[i]) begin
                            state_d[i] = ST_IDLE;
                            cnt_d[i]   = '0;
                        end else begin
                            if (edge_hit[i]) ovr_d[i] = 1'b1;
                            if (cnt_q[i] <= CNT_ONE) begin
                                state_d[i] = ST_IDLE;
                                cnt_d[i]   = '0;
                                done_d[i]  = 1'b1;
                            end else begin
                                cnt_d[i] = cnt_q[i] - CNT_ONE;
                            end
                        end
                    end
                    default: begin
                        state_d[i] = ST_IDLE;
                        cnt_d[i]   = '0;
                    end
                endcase
            end
            tx_cek_d[i] = (state_d[i] == ST_PULSE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_q   <= '1;
            tx_cek_q <= '0;
            done_q   <= '0;
            ovr_q    <= '0;
            irq_q    <= 1'b0;
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= ST_IDLE;
                cnt_q[i]   <= '0;
            end
        end else begin
            prev_q   <= tx_en;
            tx_cek_q <= tx_cek_d;
            done_q   <= done_d;
            ovr_q    <= ovr_d;
            irq_q    <= |(done_q & irq_en);
            for (int i = 0; i < NCH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
        end
    end

    assign tx_cek = tx_cek_q;
    assign done   = done_q;
    assign ovr    = ovr_q;
    assign irq    = irq_q;

endmodule

// File: tb/tb_tx_edge_pulse.sv
// Scoreboard bench for tx_edge_pulse: a window-based reference model queues the expected outputs
// per cycle, and an independent monitor pops and compares them on the falling clock edge.
module tb_tx_edge_pulse;

    localparam int NCH   = 4;
    localparam int CNT_W = 4;

    typedef struct packed {
        int             cyc;
        logic [NCH-1:0] tx_cek;
        logic [NCH-1:0] done;
        logic [NCH-1:0] ovr;
        logic           irq;
    } out_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NCH-1:0]   tx_en = '1;
    logic [1:0]       mode = 2'b00;
    logic [CNT_W-1:0] delay = '0;
    logic [CNT_W-1:0] pulse_len = '0;
    logic [NCH-1:0]   done_clr = '0;
    logic [NCH-1:0]   irq_en = '0;
    logic [NCH-1:0]   tx_cek, done, ovr;
    logic             irq;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    bit   ending = 1'b0;
    out_t exp_q[$];
    out_t anchor[int];

    // Reference model: each busy channel tracks its pulse window [start, stop] in absolute cycles.
    bit             m_prev[NCH];
    bit             m_busy[NCH];
    bit             m_pre[NCH];
    int             m_start[NCH];
    int             m_stop[NCH];
    logic [NCH-1:0] m_done, m_ovr;

    tx_edge_pulse #(.NCH(NCH), .CNT_W(CNT_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_en    (tx_en),
        .mode     (mode),
        .delay    (delay),
        .pulse_len(pulse_len),
        .done_clr (done_clr),
        .irq_en   (irq_en),
        .tx_cek   (tx_cek),
        .done     (done),
        .ovr      (ovr),
        .irq      (irq)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        out_t e;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            if (e.cyc != cyc) begin
                chk("stale_entry", 32'(e.cyc), 32'(cyc));
            end else begin
                chk("tx_cek", 32'(tx_cek), 32'(e.tx_cek));
                chk("done", 32'(done), 32'(e.done));
                chk("ovr", 32'(ovr), 32'(e.ovr));
                chk("irq", 32'(irq), 32'(e.irq));
            end
        end
        if (anchor.exists(cyc)) begin
            e = anchor[cyc];
            chk("anchor_tx_cek", 32'(tx_cek), 32'(e.tx_cek));
            chk("anchor_done", 32'(done), 32'(e.done));
            chk("anchor_ovr", 32'(ovr), 32'(e.ovr));
            chk("anchor_irq", 32'(irq), 32'(e.irq));
            anchor.delete(cyc);
        end
        if (ending) begin
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("anchors_consumed", 32'(anchor.num()), 32'd0);
            ending = 1'b0;
        end
    end

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_prev[i] = 1'b1;
            m_busy[i] = 1'b0;
        end
        m_done = '0;
        m_ovr  = '0;
    endtask

    // Consumes this cycle's inputs and queues the outputs expected during the next cycle.
    task automatic model_step();
        out_t           e;
        logic [NCH-1:0] nd, no;
        int             c, len;
        bit             r, f, hit;
        c    = cyc;
        len  = (pulse_len == '0) ? 1 : int'(pulse_len);
        nd   = m_done & ~done_clr;
        no   = m_ovr & ~done_clr;
        e.tx_cek = '0;
        for (int i = 0; i < NCH; i++) begin
            r   = !m_prev[i] && tx_en[i];
            f   = m_prev[i] && !tx_en[i];
            hit = (mode == 2'b00 && f) || (mode == 2'b01 && r) || (mode == 2'b10 && (r || f));
            if (mode == 2'b11) begin
                m_busy[i] = 1'b0;
            end else if (m_busy[i]) begin
                if (mode != 2'b10 && tx_en[i] == m_pre[i]) begin
                    m_busy[i] = 1'b0;
                end else begin
                    if (hit) no[i] = 1'b1;
                    if (m_stop[i] < 0 && c == m_start[i] - 1) m_stop[i] = m_start[i] + len - 1;
                    if (c == m_stop[i]) begin
                        m_busy[i] = 1'b0;
                        nd[i]     = 1'b1;
                    end
                end
            end else if (hit) begin
                m_busy[i]  = 1'b1;
                m_pre[i]   = m_prev[i];
                m_start[i] = c + 1 + int'(delay);
                m_stop[i]  = (delay == '0) ? c + len : -1;
            end
            if (m_busy[i] && c + 1 >= m_start[i]) e.tx_cek[i] = 1'b1;
            m_prev[i] = tx_en[i];
        end
        e.irq  = |(m_done & irq_en);
        m_done = nd;
        m_ovr  = no;
        e.done = nd;
        e.ovr  = no;
        e.cyc  = c + 1;
        exp_q.push_back(e);
    endtask

    task automatic next_cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) next_cycle();
    endtask

    // Asserted just after a rising edge: outputs must already be zero within this cycle.
    task automatic apply_reset(input int n);
        out_t z;
        reset = 1'b0;
        while (exp_q.size() > 0 && exp_q[exp_q.size()-1].cyc >= cyc) exp_q.delete(exp_q.size()-1);
        z = '0;
        z.cyc = cyc;
        exp_q.push_back(z);
        model_reset();
        repeat (n) begin
            z.cyc = cyc + 1;
            exp_q.push_back(z);
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic set_anchor(input int at, input logic [NCH-1:0] c, input logic [NCH-1:0] d,
                              input logic [NCH-1:0] o, input logic q);
        out_t a;
        a.cyc    = at;
        a.tx_cek = c;
        a.done   = d;
        a.ovr    = o;
        a.irq    = q;
        anchor[at] = a;
    endtask

    initial begin
        int k;
        @(posedge clk);
        #1;
        irq_en = '1;
        apply_reset(3);

        // Single falling edge, no delay, one-cycle pulse, then done and irq.
        mode = 2'b00; delay = 4'd0; pulse_len = 4'd1;
        run(2);
        k = cyc;
        set_anchor(k + 1, 4'b0001, 4'b0000, 4'b0000, 1'b0);
        set_anchor(k + 2, 4'b0000, 4'b0001, 4'b0000, 1'b0);
        set_anchor(k + 3, 4'b0000, 4'b0001, 4'b0000, 1'b1);
        tx_en = 4'b1110;
        run(5);

        // Delayed pulse; delay and pulse_len changes after loading must not matter.
        tx_en = '1;
        apply_reset(2);
        delay = 4'd3; pulse_len = 4'd4;
        run(2);
        tx_en = 4'b1110;
        next_cycle();
        delay = 4'd9;
        run(3);
        pulse_len = 4'd1;
        run(6);

        // Abort during WAIT: line returns high one cycle after falling.
        tx_en = '1;
        apply_reset(2);
        delay = 4'd2; pulse_len = 4'd4;
        run(2);
        tx_en = 4'b1110;
        next_cycle();
        tx_en = 4'b1111;
        run(6);

        // Both-edge mode: second edge mid-pulse sets ovr; set beats a coincident done_clr.
        tx_en = '1;
        apply_reset(2);
        mode = 2'b10; delay = 4'd0; pulse_len = 4'd5;
        run(2);
        k = cyc;
        set_anchor(k + 1, 4'b0100, 4'b0000, 4'b0000, 1'b0);
        set_anchor(k + 3, 4'b0100, 4'b0000, 4'b0100, 1'b0);
        set_anchor(k + 6, 4'b0000, 4'b0100, 4'b0000, 1'b0);
        set_anchor(k + 7, 4'b0000, 4'b0100, 4'b0000, 1'b1);
        tx_en = 4'b1011;
        run(2);
        tx_en = 4'b1111;
        run(3);
        done_clr = 4'b0100;
        next_cycle();
        done_clr = '0;
        run(3);

        // Reset mid-pulse on channel 1, release with tx_en low in falling mode.
        tx_en = '1;
        apply_reset(2);
        mode = 2'b00; delay = 4'd2; pulse_len = 4'd6;
        run(2);
        tx_en = 4'b1101;
        run(5);
        tx_en = '0;
        apply_reset(2);
        run(12);

        // All channels together, then disable mid-pulse.
        tx_en = '1;
        apply_reset(2);
        mode = 2'b00; delay = 4'd1; pulse_len = 4'd5;
        run(2);
        tx_en = '0;
        run(4);
        mode = 2'b11;
        run(3);
        mode = 2'b00;
        tx_en = '1;
        run(3);

        // Randomized segments; mode only changes through the disabled state.
        for (int s = 0; s < 40; s++) begin
            if (s == 20) apply_reset(2);
            mode = 2'b11;
            next_cycle();
            mode      = 2'($urandom_range(0, 2));
            delay     = ($urandom_range(0, 3) == 0) ? 4'd0 : CNT_W'($urandom_range(1, 6));
            pulse_len = CNT_W'($urandom_range(0, 7));
            irq_en    = NCH'($urandom);
            for (int j = 0; j < 30; j++) begin
                for (int i = 0; i < NCH; i++)
                    if ($urandom_range(0, 5) == 0) tx_en[i] = ~tx_en[i];
                done_clr = ($urandom_range(0, 7) == 0) ? NCH'($urandom) : '0;
                if ($urandom_range(0, 9) == 0) begin
                    delay     = CNT_W'($urandom_range(0, 5));
                    pulse_len = CNT_W'($urandom_range(0, 7));
                end
                if ($urandom_range(0, 9) == 0) irq_en = NCH'($urandom);
                if (j == 15 && $urandom_range(0, 3) == 0) mode = 2'b11;
                next_cycle();
            end
        end
        done_clr = '0;

        ending = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
